// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : alu_pkg                                                |
// | Description : Shared types and defaults for the ALU sequential       |
// |               multiplier (FSM state encoding, default width).        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam int MULT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mult_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : seq_mult_if                                            |
// | Description : Operand/product handshake bundle for seq_mult.         |
// |               master = producer/consumer side, slave = multiplier.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface seq_mult_if
    import alu_pkg::*;
#(
    parameter int WIDTH = MULT_W_DEFAULT
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product
    );
endinterface
`default_nettype wire

// File: rtl/full_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : full_add                                               |
// | Description : One-bit full adder cell.                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module full_add (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule
`default_nettype wire

// File: rtl/rca_add.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rca_add                                                |
// | Description : WIDTH-bit ripple-carry adder, a + b + cin, built from  |
// |               full_add cells.                                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rca_add #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    input  wire logic             cin,
    output logic      [WIDTH-1:0] sum,
    output logic                  cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[WIDTH];

    // Carry ripples LSB to MSB through one cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_add u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end
endmodule
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_mult                                               |
// | Description : Iterative shift-add multiplier, one partial product    |
// |               per cycle, signed/unsigned, valid/ready handshake.     |
// |               Signed operands are reduced to magnitudes up front and |
// |               the sign is re-applied in a single fix-up cycle.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = MULT_W_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst_n,
    seq_mult_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                 state_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [2*WIDTH-1:0]     product_q;
    logic [WIDTH-1:0]       mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [WIDTH-1:0]       acc_hi_q;
    logic                   neg_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [WIDTH-1:0]       mag_a_d;
    logic [WIDTH-1:0]       mag_b_d;
    logic                   neg_d;
    logic [WIDTH-1:0]       addend_d;
    logic [WIDTH-1:0]       sum_d;
    logic                   cout_d;
    logic [2*WIDTH-1:0]     full_d;
    logic [2*WIDTH-1:0]     prod_d;

    // Operand magnitudes: only negate when the operand is signed and negative.
    // The most negative value negates to itself, which reads correctly as unsigned.
    assign mag_a_d = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    assign mag_b_d = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    assign neg_d   = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

    // Partial product for the current multiplier LSB.
    assign addend_d = mplier_q[0] ? mcand_q : '0;

    rca_add #(
        .WIDTH (WIDTH)
    ) u_acc_add (
        .a    (acc_hi_q),
        .b    (addend_d),
        .cin  (1'b0),
        .sum  (sum_d),
        .cout (cout_d)
    );

    // Low half of the result lives in mplier_q once all bits are shifted out.
    assign full_d = {acc_hi_q, mplier_q};
    assign prod_d = neg_q ? (~full_d + (2*WIDTH)'(1)) : full_d;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;

    // Control FSM and datapath registers: accept, iterate WIDTH times, sign fix, hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_hi_q    <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q    <= mag_a_d;
                        mplier_q   <= mag_b_d;
                        neg_q      <= neg_d;
                        acc_hi_q   <= '0;
                        cnt_q      <= CNT_INIT;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // {carry, sum, mplier} shifted right by one.
                    acc_hi_q <= {cout_d, sum_d[WIDTH-1:1]};
                    mplier_q <= {sum_d[0], mplier_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    product_q   <= prod_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_seq_mult                                            |
// | Description : Self-checking bench for seq_mult at WIDTH=8 and 4,     |
// |               against an arithmetic reference model.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_seq_mult;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    seq_mult_if #(.WIDTH(8)) if8 ();
    seq_mult_if #(.WIDTH(4)) if4 ();

    seq_mult #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    seq_mult #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer product of the operands interpreted per mode, modulo 2^(2W).
    function automatic logic [15:0] model8(input logic [7:0] ma, input logic [7:0] mb, input logic msm);
        longint sa, sb, p;
        sa = msm ? longint'($signed(ma)) : longint'(ma);
        sb = msm ? longint'($signed(mb)) : longint'(mb);
        p  = sa * sb;
        return p[15:0];
    endfunction

    function automatic logic [7:0] model4(input logic [3:0] ma, input logic [3:0] mb, input logic msm);
        longint sa, sb, p;
        sa = msm ? longint'($signed(ma)) : longint'(ma);
        sb = msm ? longint'($signed(mb)) : longint'(mb);
        p  = sa * sb;
        return p[7:0];
    endfunction

    // Present operands when ready; returns #1 after the handshake edge.
    task automatic start8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm);
        int n;
        n = 0;
        while (!if8.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (if8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start8_in_ready: got %b expected 1", if8.in_ready);
        end
        if8.in_valid = 1'b1; if8.a = ta; if8.b = tb; if8.signed_mode = tsm;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
    endtask

    // Count edges until out_valid is seen (capped at 50).
    task automatic wait_valid8(output int lat);
        lat = 0;
        while (!if8.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic pop8();
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
        checks++;
        if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pop8: out_valid=%b in_ready=%b expected 0/1", if8.out_valid, if8.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.product !== 16'h0) begin
            errors++;
            $display("FAIL reset8: in_ready=%b out_valid=%b product=%h expected 1/0/0000",
                     if8.in_ready, if8.out_valid, if8.product);
        end
        checks++;
        if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0 || if4.product !== 8'h0) begin
            errors++;
            $display("FAIL reset4: in_ready=%b out_valid=%b product=%h expected 1/0/00",
                     if4.in_ready, if4.out_valid, if4.product);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0]  da [4] = '{8'hFF, 8'h80, 8'hFD, 8'hFD};
        logic [7:0]  db [4] = '{8'hFF, 8'h80, 8'h05, 8'h05};
        logic        ds [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] dp [4] = '{16'hFE01, 16'h4000, 16'hFFF1, 16'h04F1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start8(da[i], db[i], ds[i]);
            wait_valid8(lat);
            checks++;
            if (lat != 9) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected 9", i, lat);
            end
            checks++;
            if (if8.product !== dp[i]) begin
                errors++;
                $display("FAIL directed_product[%0d]: got %h expected %h", i, if8.product, dp[i]);
            end
            pop8();
        end
    endtask

    task automatic test_random8();
        logic [7:0]  ra, rb;
        logic        rs;
        logic [15:0] exp_p;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            exp_p = model8(ra, rb, rs);
            start8(ra, rb, rs);
            wait_valid8(lat);
            checks++;
            if (if8.product !== exp_p || lat != 9) begin
                errors++;
                $display("FAIL random8[%0d]: %h*%h sm=%b got %h lat=%0d expected %h lat=9",
                         i, ra, rb, rs, if8.product, lat, exp_p);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            pop8();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_p;
        int lat;
        exp_p = model8(8'hC3, 8'h5A, 1'b1);
        start8(8'hC3, 8'h5A, 1'b1);
        wait_valid8(lat);
        for (int i = 0; i < 10; i++) begin
            // Offer different operands while stalled; they must not be taken.
            if8.in_valid = 1'b1; if8.a = 8'($urandom); if8.b = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if (if8.out_valid !== 1'b1 || if8.product !== exp_p || if8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: out_valid=%b product=%h in_ready=%b expected 1/%h/0",
                         i, if8.out_valid, if8.product, if8.in_ready, exp_p);
            end
        end
        if8.in_valid = 1'b0;
        pop8();
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_p;
        int lat;
        start8(8'h7B, 8'hE2, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (if8.out_valid !== 1'b0 || if8.product !== 16'h0 || if8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b product=%h in_ready=%b expected 0/0000/1",
                     if8.out_valid, if8.product, if8.in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_p = model8(8'h9C, 8'h37, 1'b1);
        start8(8'h9C, 8'h37, 1'b1);
        wait_valid8(lat);
        checks++;
        if (if8.product !== exp_p || lat != 9) begin
            errors++;
            $display("FAIL reset_mid_next: got %h lat=%0d expected %h lat=9", if8.product, lat, exp_p);
        end
        pop8();
    endtask

    task automatic test_ignore();
        logic [15:0] exp_p;
        int lat;
        exp_p = model8(8'h2D, 8'hB1, 1'b1);
        start8(8'h2D, 8'hB1, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if8.in_valid = 1'b1; if8.a = 8'hFF; if8.b = 8'h7F; if8.signed_mode = 1'b0;
            checks++;
            if (if8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ignore_in_ready[%0d]: got %b expected 0", i, if8.in_ready);
            end
            @(posedge clk); #1;
        end
        if8.in_valid = 1'b0;
        wait_valid8(lat);
        checks++;
        if (if8.out_valid !== 1'b1 || if8.product !== exp_p) begin
            errors++;
            $display("FAIL ignore_product: out_valid=%b got %h expected %h", if8.out_valid, if8.product, exp_p);
        end
        pop8();
    endtask

    // All 4-bit pairs in both modes, back to back, out_ready tied high.
    task automatic test_back_to_back();
        logic [7:0] expq [$];
        logic [7:0] exp_p;
        int idx, done_cnt, cyc, last;
        idx = 0; done_cnt = 0; cyc = 0; last = -1;
        if4.out_ready = 1'b1;
        while (done_cnt < 512 && cyc < 10000) begin
            if (idx < 512 && if4.in_ready) begin
                if4.in_valid = 1'b1;
                if4.a = idx[3:0]; if4.b = idx[7:4]; if4.signed_mode = idx[8];
                expq.push_back(model4(idx[3:0], idx[7:4], idx[8]));
                idx++;
            end else begin
                // Junk offered while busy must be ignored.
                if4.in_valid = 1'b1;
                if4.a = 4'($urandom); if4.b = 4'($urandom); if4.signed_mode = 1'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
            if (if4.out_valid) begin
                exp_p = (expq.size() > 0) ? expq.pop_front() : 8'hXX;
                checks++;
                if (if4.product !== exp_p) begin
                    errors++;
                    $display("FAIL exhaustive4[%0d]: got %h expected %h", done_cnt, if4.product, exp_p);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 7) begin
                        errors++;
                        $display("FAIL throughput4[%0d]: got %0d cycles expected 7", done_cnt, cyc - last);
                    end
                end
                last = cyc;
                done_cnt++;
            end
        end
        if4.in_valid = 1'b0;
        checks++;
        if (done_cnt != 512) begin
            errors++;
            $display("FAIL exhaustive4_count: got %0d expected 512", done_cnt);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.signed_mode = 1'b0; if8.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.signed_mode = 1'b0; if4.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_directed();
        test_random8();
        test_backpressure();
        test_reset_mid();
        test_ignore();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
